// File: rtl/overlap_framer.sv
// overlap_framer: streaming framer with overlap between ADC input and FFT chain.
// Samples go into a circular buffer; every HOP samples (after the first
// FRAME_LEN) a FRAME_LEN-sample frame is streamed out with first/last tags.
// Optional input pre-emphasis is enabled by defining OVERLAP_FRAMER_PREEMPH_EN.
module overlap_framer #(
    parameter int DATA_W    = 12,
    parameter int FRAME_LEN = 64,
    parameter int HOP       = 32,
    parameter int DEPTH     = 128
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              s_valid,
    input  logic [DATA_W-1:0] s_data,
    output logic              m_valid,
    input  logic              m_ready,
    output logic [DATA_W-1:0] m_data,
    output logic              m_first,
    output logic              m_last,
    output logic [15:0]       frame_cnt,
    output logic              overrun
);

    localparam int AW = $clog2(DEPTH);
    localparam int PW = AW + 1;
    localparam int IW = $clog2(FRAME_LEN);
    localparam int CW = IW + 1;

    typedef enum logic [1:0] {
        S_PRIME = 2'd0,
        S_IDLE  = 2'd1,
        S_READ  = 2'd2
    } state_t;

    logic              w_valid;
    logic [DATA_W-1:0] w_data;

`ifdef OVERLAP_FRAMER_PREEMPH_EN
    localparam int EW = DATA_W + 2;

    logic              pe_valid_q;
    logic [DATA_W-1:0] pe_data_q;
    logic [DATA_W-1:0] x_prev_q;
    logic signed [EW-1:0] pe_sum_d;
    logic [DATA_W-1:0] pe_clamped_d;

    // Pre-emphasis y = x - x_prev + x_prev/32, offset to mid-scale and clamped.
    always_comb begin
        pe_sum_d = $signed({2'b00, s_data})
                 - $signed({2'b00, x_prev_q})
                 + $signed({2'b00, (x_prev_q >> 5)})
                 + $signed(EW'(2 ** (DATA_W - 1)));
        if (pe_sum_d[EW-1]) begin
            pe_clamped_d = '0;
        end else if (pe_sum_d[DATA_W]) begin
            pe_clamped_d = '1;
        end else begin
            pe_clamped_d = pe_sum_d[DATA_W-1:0];
        end
    end

    // Extra write-path stage holding the filtered sample and the filter history.
    always_ff @(posedge clk) begin
        if (rst) begin
            pe_valid_q <= 1'b0;
            pe_data_q  <= '0;
            x_prev_q   <= '0;
        end else begin
            pe_valid_q <= s_valid;
            if (s_valid) begin
                pe_data_q <= pe_clamped_d;
                x_prev_q  <= s_data;
            end
        end
    end

    assign w_valid = pe_valid_q;
    assign w_data  = pe_data_q;
`else
    assign w_valid = s_valid;
    assign w_data  = s_data;
`endif

    logic [DATA_W-1:0] mem_q [DEPTH];

    state_t            state_q;
    logic [PW-1:0]     wr_ptr_q;
    logic [PW-1:0]     rd_ptr_q;
    logic [PW-1:0]     pend_start_q;
    logic              pending_q;
    logic [CW-1:0]     cnt_q;
    logic [IW-1:0]     idx_q;
    logic              m_valid_q;
    logic              m_first_q;
    logic              m_last_q;
    logic [DATA_W-1:0] m_data_q;
    logic [15:0]       frame_cnt_q;
    logic              overrun_q;

    logic [PW-1:0]     fill_rd_d;
    logic [PW-1:0]     fill_pd_d;
    logic              full_d;
    logic              w_fire_d;
    logic [CW-1:0]     cnt_inc_d;
    logic              trig_d;
    logic [PW-1:0]     trig_start_d;
    logic              issue_d;
    logic              finish_d;

    // Occupancy against the oldest unread sample, frame trigger and read issue decisions.
    always_comb begin
        fill_rd_d    = wr_ptr_q - rd_ptr_q;
        fill_pd_d    = wr_ptr_q - pend_start_q;
        full_d       = ((state_q == S_READ) && (fill_rd_d >= PW'(DEPTH)))
                     || (pending_q && (fill_pd_d >= PW'(DEPTH)));
        w_fire_d     = w_valid && !full_d;
        cnt_inc_d    = cnt_q + CW'(1);
        trig_d       = w_fire_d
                     && (cnt_inc_d == ((state_q == S_PRIME) ? CW'(FRAME_LEN) : CW'(HOP)));
        trig_start_d = wr_ptr_q + PW'(1) - PW'(FRAME_LEN);
        issue_d      = (state_q == S_READ) && (!m_valid_q || m_ready);
        finish_d     = issue_d && (idx_q == IW'(FRAME_LEN - 1));
    end

    // Circular sample buffer; contents are don't-care after reset.
    always_ff @(posedge clk) begin
        if (w_fire_d) begin
            mem_q[wr_ptr_q[AW-1:0]] <= w_data;
        end
    end

    // Write pointer, trigger counter, framing FSM, pending slot and output register.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= S_PRIME;
            wr_ptr_q     <= '0;
            rd_ptr_q     <= '0;
            pend_start_q <= '0;
            pending_q    <= 1'b0;
            cnt_q        <= '0;
            idx_q        <= '0;
            m_valid_q    <= 1'b0;
            m_first_q    <= 1'b0;
            m_last_q     <= 1'b0;
            m_data_q     <= '0;
            frame_cnt_q  <= '0;
            overrun_q    <= 1'b0;
        end else begin
            if (w_valid) begin
                if (full_d) begin
                    overrun_q <= 1'b1;
                end else begin
                    wr_ptr_q <= wr_ptr_q + PW'(1);
                end
            end

            if (trig_d) begin
                cnt_q <= '0;
            end else if (w_fire_d) begin
                cnt_q <= cnt_inc_d;
            end

            if (m_valid_q && m_ready) begin
                m_valid_q <= 1'b0;
                if (m_last_q) begin
                    frame_cnt_q <= frame_cnt_q + 16'd1;
                end
            end

            if (issue_d) begin
                m_valid_q <= 1'b1;
                m_data_q  <= mem_q[rd_ptr_q[AW-1:0]];
                m_first_q <= (idx_q == '0);
                m_last_q  <= finish_d;
                rd_ptr_q  <= rd_ptr_q + PW'(1);
                idx_q     <= idx_q + IW'(1);
            end

            case (state_q)
                S_PRIME: begin
                    if (trig_d) begin
                        state_q  <= S_READ;
                        rd_ptr_q <= trig_start_d;
                        idx_q    <= '0;
                    end
                end
                S_IDLE: begin
                    if (pending_q) begin
                        state_q   <= S_READ;
                        rd_ptr_q  <= pend_start_q;
                        idx_q     <= '0;
                        pending_q <= 1'b0;
                        if (trig_d) begin
                            pending_q    <= 1'b1;
                            pend_start_q <= trig_start_d;
                        end
                    end else if (trig_d) begin
                        state_q  <= S_READ;
                        rd_ptr_q <= trig_start_d;
                        idx_q    <= '0;
                    end
                end
                S_READ: begin
                    if (finish_d) begin
                        if (pending_q) begin
                            rd_ptr_q  <= pend_start_q;
                            idx_q     <= '0;
                            pending_q <= 1'b0;
                        end else begin
                            state_q <= S_IDLE;
                        end
                    end
                    if (trig_d) begin
                        if (pending_q && !finish_d) begin
                            overrun_q <= 1'b1;
                        end else begin
                            pending_q    <= 1'b1;
                            pend_start_q <= trig_start_d;
                        end
                    end
                end
                default: begin
                    state_q <= S_PRIME;
                end
            endcase
        end
    end

    assign m_valid   = m_valid_q;
    assign m_data    = m_data_q;
    assign m_first   = m_first_q;
    assign m_last    = m_last_q;
    assign frame_cnt = frame_cnt_q;
    assign overrun   = overrun_q;

endmodule

// File: tb/tb_overlap_framer.sv
// tb_overlap_framer: self-checking bench for overlap_framer.
// Expected frames come from a sample-history model: every accepted sample is
// appended to a list, and whenever the count reaches FRAME_LEN + k*HOP the
// last FRAME_LEN samples are queued as the next expected frame.
module tb_overlap_framer;

    localparam int DATA_W    = 12;
    localparam int FRAME_LEN = 64;
    localparam int HOP       = 32;
    localparam int DEPTH     = 128;
`ifdef OVERLAP_FRAMER_PREEMPH_EN
    localparam int LAT = 3;
`else
    localparam int LAT = 2;
`endif

    logic              clk = 1'b0;
    logic              rst = 1'b0;
    logic              s_valid = 1'b0;
    logic [DATA_W-1:0] s_data = '0;
    logic              m_valid;
    logic              m_ready = 1'b0;
    logic [DATA_W-1:0] m_data;
    logic              m_first;
    logic              m_last;
    logic [15:0]       frame_cnt;
    logic              overrun;

    typedef struct {
        logic [DATA_W-1:0] data;
        bit                first;
        bit                last;
    } beat_t;

    beat_t             expQ[$];
    logic [DATA_W-1:0] hist[$];
    int                modelFrames = 0;
    int                xPrev = 0;
    int                vecCount = 0;
    int                errCount = 0;
    bit                monEn = 1'b0;
    int                hsCount = 0;
    int                lastCount = 0;
    bit                stallPending = 1'b0;
    logic [DATA_W-1:0] stallData = '0;
    bit                stallFirst = 1'b0;
    bit                stallLast = 1'b0;

    overlap_framer #(
        .DATA_W(DATA_W), .FRAME_LEN(FRAME_LEN), .HOP(HOP), .DEPTH(DEPTH)
    ) dut (
        .clk(clk), .rst(rst), .s_valid(s_valid), .s_data(s_data),
        .m_valid(m_valid), .m_ready(m_ready), .m_data(m_data),
        .m_first(m_first), .m_last(m_last), .frame_cnt(frame_cnt), .overrun(overrun)
    );

    // 100 MHz clock
    always #5 clk = ~clk;

    // Input transform of the model: identity, or the 31/32 pre-emphasis filter.
    function automatic logic [DATA_W-1:0] modelTransform(input logic [DATA_W-1:0] x);
`ifdef OVERLAP_FRAMER_PREEMPH_EN
        int y;
        y = int'(x) - xPrev + (xPrev / 32) + 2048;
        xPrev = int'(x);
        if (y < 0) y = 0;
        if (y > 4095) y = 4095;
        return DATA_W'(y);
`else
        return x;
`endif
    endfunction

    function automatic void modelReset();
        hist.delete();
        expQ.delete();
        modelFrames = 0;
        xPrev = 0;
    endfunction

    // Append an accepted sample; queue a frame at FRAME_LEN, FRAME_LEN+HOP, ...
    function automatic void modelPush(input logic [DATA_W-1:0] x);
        int    n;
        beat_t b;
        hist.push_back(modelTransform(x));
        n = hist.size();
        if (n >= FRAME_LEN && ((n - FRAME_LEN) % HOP) == 0) begin
            for (int i = 0; i < FRAME_LEN; i++) begin
                b.data  = hist[n - FRAME_LEN + i];
                b.first = (i == 0);
                b.last  = (i == FRAME_LEN - 1);
                expQ.push_back(b);
            end
            modelFrames++;
        end
    endfunction

    // Drive one cycle of inputs just after the rising edge.
    task automatic applyStimulus(input bit sv, input logic [DATA_W-1:0] sd, input bit rdy);
        @(posedge clk);
        #1;
        s_valid = sv;
        s_data  = sd;
        m_ready = rdy;
        if (sv) modelPush(sd);
    endtask

    task automatic doReset();
        @(posedge clk);
        #1;
        rst     = 1'b1;
        s_valid = 1'b0;
        m_ready = 1'b0;
        monEn   = 1'b0;
        @(posedge clk);
        @(posedge clk);
        #1;
        rst = 1'b0;
        modelReset();
    endtask

    // Run idle input cycles until all expected beats are out (mode 0: ready, 1: toggle, 2: random).
    task automatic drainOutput(input int mode);
        bit tog = 1'b0;
        bit rdy;
        for (int c = 0; c < 3000; c++) begin
            tog = ~tog;
            rdy = (mode == 0) ? 1'b1 : (mode == 1) ? tog : ($urandom_range(3, 0) != 0);
            applyStimulus(1'b0, '0, rdy);
            if (expQ.size() == 0 && m_valid === 1'b0) break;
        end
        vecCount++;
        if (expQ.size() != 0 || m_valid !== 1'b0) begin
            errCount++;
            $display("[TB] FAIL drain_timeout beats_left=%0d m_valid=%b want 0/0", expQ.size(), m_valid);
        end
    endtask

    // Scoreboard: every handshake must match the next model beat; stalled outputs must hold.
    always @(negedge clk) begin
        beat_t b;
        if (!monEn) begin
            stallPending = 1'b0;
        end else begin
            if (stallPending) begin
                vecCount++;
                if (m_valid !== 1'b1 || m_data !== stallData || m_first !== stallFirst || m_last !== stallLast) begin
                    errCount++;
                    $display("[TB] FAIL stall_hold got v=%b d=%0d f=%b l=%b want v=1 d=%0d f=%b l=%b",
                             m_valid, m_data, m_first, m_last, stallData, stallFirst, stallLast);
                end
            end
            if (m_valid === 1'b1 && m_ready === 1'b1) begin
                hsCount++;
                if (m_last === 1'b1) lastCount++;
                vecCount++;
                if (expQ.size() == 0) begin
                    errCount++;
                    $display("[TB] FAIL unexpected_beat got d=%0d f=%b l=%b want no beat", m_data, m_first, m_last);
                end else begin
                    b = expQ.pop_front();
                    if (m_data !== b.data || m_first !== b.first || m_last !== b.last) begin
                        errCount++;
                        $display("[TB] FAIL stream_beat got d=%0d f=%b l=%b want d=%0d f=%b l=%b",
                                 m_data, m_first, m_last, b.data, b.first, b.last);
                    end
                end
            end
            stallPending = (m_valid === 1'b1 && m_ready === 1'b0);
            stallData    = m_data;
            stallFirst   = m_first;
            stallLast    = m_last;
        end
    end

    task automatic test_reset();
        doReset();
        vecCount++;
        if (m_valid !== 1'b0) begin
            errCount++;
            $display("[TB] FAIL reset_m_valid got %b want 0", m_valid);
        end
        vecCount++;
        if ({m_data, m_first, m_last} !== '0) begin
            errCount++;
            $display("[TB] FAIL reset_data got d=%0d f=%b l=%b want 0", m_data, m_first, m_last);
        end
        vecCount++;
        if (frame_cnt !== 16'd0 || overrun !== 1'b0) begin
            errCount++;
            $display("[TB] FAIL reset_status got cnt=%0d ovr=%b want 0/0", frame_cnt, overrun);
        end
    endtask

    task automatic test_first_frame();
        monEn = 1'b1;
        lastCount = 0;
        for (int v = 0; v < FRAME_LEN; v++) begin
            applyStimulus(1'b1, DATA_W'(v), 1'b1);
            if (v != FRAME_LEN - 1) begin
                repeat (3) applyStimulus(1'b0, '0, 1'b1);
            end
        end
        applyStimulus(1'b0, '0, 1'b1);
        for (int k = 1; k < LAT; k++) begin
            @(negedge clk);
            vecCount++;
            if (m_valid !== 1'b0) begin
                errCount++;
                $display("[TB] FAIL latency_early got m_valid=%b want 0 at cycle %0d", m_valid, k);
            end
        end
        @(negedge clk);
        vecCount++;
        if (m_valid !== 1'b1 || m_first !== 1'b1 || m_data !== hist[0]) begin
            errCount++;
            $display("[TB] FAIL latency_first got v=%b f=%b d=%0d want v=1 f=1 d=%0d", m_valid, m_first, m_data, hist[0]);
        end
        drainOutput(0);
        vecCount++;
        if (frame_cnt !== 16'd1 || lastCount != 1) begin
            errCount++;
            $display("[TB] FAIL first_frame_count got cnt=%0d lasts=%0d want 1/1", frame_cnt, lastCount);
        end
    endtask

    task automatic test_ramp_continue();
        for (int v = FRAME_LEN; v < 160; v++) begin
            applyStimulus(1'b1, DATA_W'(v), 1'b1);
            repeat (3) applyStimulus(1'b0, '0, 1'b1);
        end
        drainOutput(0);
        vecCount++;
        if (frame_cnt !== 16'd4 || overrun !== 1'b0) begin
            errCount++;
            $display("[TB] FAIL ramp_frames got cnt=%0d ovr=%b want 4/0", frame_cnt, overrun);
        end
    endtask

    task automatic test_backpressure();
        bit tog = 1'b0;
        lastCount = 0;
        for (int v = 160; v < 192; v++) begin
            for (int c = 0; c < 4; c++) begin
                tog = ~tog;
                applyStimulus(c == 0, DATA_W'(v), tog);
            end
        end
        drainOutput(1);
        vecCount++;
        if (lastCount != 1 || frame_cnt !== 16'd5) begin
            errCount++;
            $display("[TB] FAIL backpressure_last got lasts=%0d cnt=%0d want 1/5", lastCount, frame_cnt);
        end
    endtask

    task automatic test_random();
        for (int i = 0; i < 160; i++) begin
            for (int c = 0; c < 4; c++) begin
                applyStimulus(c == 0, DATA_W'($urandom), $urandom_range(3, 0) != 0);
            end
        end
        drainOutput(2);
        vecCount++;
        if (frame_cnt !== 16'(modelFrames) || overrun !== 1'b0) begin
            errCount++;
            $display("[TB] FAIL random_frames got cnt=%0d ovr=%b want %0d/0", frame_cnt, overrun, modelFrames);
        end
    endtask

    task automatic test_overrun();
        doReset();
        for (int c = 0; c < 300; c++) begin
            if (c == 110) begin
                vecCount++;
                if (overrun !== 1'b0) begin
                    errCount++;
                    $display("[TB] FAIL overrun_early got %b want 0", overrun);
                end
            end
            applyStimulus(1'b1, DATA_W'($urandom), 1'b0);
        end
        applyStimulus(1'b0, '0, 1'b0);
        vecCount++;
        if (overrun !== 1'b1 || frame_cnt !== 16'd0) begin
            errCount++;
            $display("[TB] FAIL overrun_set got ovr=%b cnt=%0d want 1/0", overrun, frame_cnt);
        end
        doReset();
        vecCount++;
        if (overrun !== 1'b0 || frame_cnt !== 16'd0) begin
            errCount++;
            $display("[TB] FAIL overrun_clear got ovr=%b cnt=%0d want 0/0", overrun, frame_cnt);
        end
    endtask

    task automatic test_reset_midframe();
        doReset();
        monEn = 1'b1;
        hsCount = 0;
        for (int v = 0; v < FRAME_LEN; v++) begin
            applyStimulus(1'b1, DATA_W'(v), 1'b1);
            repeat (3) applyStimulus(1'b0, '0, 1'b1);
        end
        for (int c = 0; c < 200; c++) begin
            if (hsCount == 20) break;
            applyStimulus(1'b0, '0, 1'b1);
        end
        vecCount++;
        if (hsCount != 20) begin
            errCount++;
            $display("[TB] FAIL midframe_reach got handshakes=%0d want 20", hsCount);
        end
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        modelReset();
        @(negedge clk);
        vecCount++;
        if (m_valid !== 1'b0) begin
            errCount++;
            $display("[TB] FAIL midframe_drop got m_valid=%b want 0", m_valid);
        end
        for (int v = 0; v < FRAME_LEN; v++) begin
            applyStimulus(1'b1, DATA_W'(v + 1000), 1'b1);
            repeat (3) applyStimulus(1'b0, '0, 1'b1);
        end
        drainOutput(0);
        vecCount++;
        if (frame_cnt !== 16'd1 || overrun !== 1'b0) begin
            errCount++;
            $display("[TB] FAIL midframe_fresh got cnt=%0d ovr=%b want 1/0", frame_cnt, overrun);
        end
    endtask

`ifdef OVERLAP_FRAMER_PREEMPH_EN
    task automatic test_preemph();
        doReset();
        monEn = 1'b1;
        for (int v = 0; v < FRAME_LEN; v++) begin
            applyStimulus(1'b1, 12'd2048, 1'b1);
            repeat (3) applyStimulus(1'b0, '0, 1'b1);
        end
        for (int c = 0; c < 20; c++) begin
            if (m_valid === 1'b1) break;
            applyStimulus(1'b0, '0, 1'b1);
        end
        vecCount++;
        if (m_valid !== 1'b1 || m_data !== 12'd4095) begin
            errCount++;
            $display("[TB] FAIL preemph_first got v=%b d=%0d want 1/4095", m_valid, m_data);
        end
        applyStimulus(1'b0, '0, 1'b1);
        vecCount++;
        if (m_data !== 12'd2112) begin
            errCount++;
            $display("[TB] FAIL preemph_steady got %0d want 2112", m_data);
        end
        drainOutput(0);
        vecCount++;
        if (frame_cnt !== 16'd1) begin
            errCount++;
            $display("[TB] FAIL preemph_count got %0d want 1", frame_cnt);
        end
    endtask
`endif

    // Test sequence and summary
    initial begin
        test_reset();
        test_first_frame();
        test_ramp_continue();
        test_backpressure();
        test_random();
        test_overrun();
        test_reset_midframe();
`ifdef OVERLAP_FRAMER_PREEMPH_EN
        test_preemph();
`endif
        $display("== %0d vectors applied, %0d miscompares ==", vecCount, errCount);
        $finish;
    end

    // Watchdog so the run always ends
    initial begin
        #2000000;
        $display("[TB] FAIL watchdog_timeout simulation exceeded time limit");
        $fatal(1, "[TB] watchdog expired");
    end

endmodule

// File: doc/overlap_framer.md
Name: overlap_framer

Overview:
- Parametrised streaming framer with overlap, placed between the ADC sample input and the windowing/FFT chain.
- Writes incoming samples into a circular buffer and cuts frames of FRAME_LEN samples every HOP samples.
- Streams each frame out one sample per cycle on a valid/ready interface, with first/last tags.
- Flags overruns and optionally applies pre-emphasis on the input.

Parameters:
DATA_W, 12, sample width in bits.
FRAME_LEN, 64, samples per frame; power of two, ≥ 4.
HOP, 32, samples between frame starts; 1 ≤ HOP ≤ FRAME_LEN.
DEPTH, 128, circular buffer depth; power of two, ≥ 2*FRAME_LEN.

Ports:
clk  in  1  single clock.
rst  in  1  synchronous reset, active-high.
s_valid  in  1  input sample strobe (ADC rate); cannot be back-pressured.
s_data  in  DATA_W  unsigned input sample.
m_valid  out  1  output sample valid.
m_ready  in  1  downstream accept.
m_data  out  DATA_W  framed sample.
m_first  out  1  high with frame sample index 0.
m_last  out  1  high with frame sample index FRAME_LEN-1.
frame_cnt  out  16  frames fully emitted; wraps modulo 2^16.
overrun  out  1  sticky error flag; cleared only by rst.

Behaviour:
- Reset values: all outputs 0; write pointer 0, read pointer 0, sample counter 0, pending 0, state PRIME.
- Write side:
  - On s_valid, the sample is written at wr_ptr and wr_ptr increments modulo DEPTH.
  - Full condition: (wr_ptr - oldest unread sample of active or pending frame) mod 2*DEPTH == DEPTH. Track with an extra pointer bit.
  - A sample arriving when full is dropped, overrun is set, and wr_ptr is held.
- Frame trigger:
  - The first trigger occurs when the FRAME_LEN-th sample since reset is written.
  - Each subsequent trigger occurs every HOP written samples after that.
  - A trigger records frame start = wr_ptr_after_write - FRAME_LEN.
- States:
  - PRIME: counts samples to FRAME_LEN. On reaching it, go to READ with start latched.
  - IDLE: waits for a trigger, then goes to READ.
  - READ: issues one buffer read per cycle while the output register is empty or m_ready=1. After index FRAME_LEN-1 is issued, go to IDLE, or straight to READ when pending=1 (consuming the pending start).
- Pending slot (one deep):
  - A trigger during READ loads the pending slot.
  - A trigger while pending is already full drops that frame and sets overrun.
- Output:
  - Registered, one-cycle buffer-read latency. The first m_valid appears 2 cycles after the trigger-causing write.
  - m_data, m_first and m_last hold stable while m_valid=1 and m_ready=0. No bubble when m_ready is held high: one sample per cycle.
  - frame_cnt increments on the m_last handshake.
- Simultaneous events:
  - A write and a read of the same address in one cycle returns the old value. This cannot occur for valid data because of the full check.
  - A trigger in the same cycle that READ finishes goes to pending and is taken next cycle; the 1-cycle gap is acceptable.
- Reset mid-frame: the frame is abandoned immediately, m_valid drops the next cycle, and the buffer contents become don't-care.
- Width: pointers are log2(DEPTH)+1 bits and the sample counter is log2(FRAME_LEN)+1 bits. No arithmetic on data except the optional pre-emphasis.

Optional Feature:
- Macro: OVERLAP_FRAMER_PREEMPH_EN.
- When defined:
  - Each input is replaced by y[n] = x[n] - x[n-1] + (x[n-1] >> 5), i.e. a coefficient of 31/32.
  - Computed in DATA_W+2 signed bits, offset by +2^(DATA_W-1), then clamped to [0, 2^DATA_W-1].
  - x[-1] = 0 after reset.
  - Adds one register stage on the write path, so every write-side event is one cycle later.
- When not defined: samples are stored unmodified with no extra stage.

Test Plan:
- Reset, then 64 samples with values 0..63 (s_valid every 4th cycle), m_ready=1 → one frame 0..63 with m_first on 0 and m_last on 63, m_valid at cycle+2 after the 64th write, frame_cnt=1.
- Continue the ramp to 160 samples → frames starting at 32 and 64 (data 32..95 and 64..127, 96..159 follows), all contiguous, overrun=0.
- Backpressure by toggling m_ready every cycle during a frame → m_data stable across stalls, no duplicates or skips, m_last exactly once.
- m_ready=0 held while s_valid is high every cycle for 300 cycles → overrun=1 once the pending slot is full or the buffer is full, frame_cnt unchanged; after a later rst, overrun=0.
- Assert rst at frame index 20 → m_valid=0 the next cycle, and a fresh 64-sample ramp yields a clean frame with frame_cnt=1.
- With OVERLAP_FRAMER_PREEMPH_EN and constant input 2048 → first stored value clamps to 4095, steady state ≈ 2048 + 64 = 2112.
